// File: rtl/joystick_scan.sv
// Scans PADS serial shift-register game pads over a shared clock/load/data bus and
// publishes them as one active-high bus. Define JOYSCAN_DEBOUNCE_EN to commit a frame only when two consecutive scans agree.
module joystick_scan #(
    parameter int PADS = 2,
    parameter int BITS = 8,
    parameter int SELW = 1
) (
    input  logic                 clock,
    input  logic                 power,
    input  logic                 ce,
    output logic                 joyCk,
    output logic                 joyLd,
    output logic [SELW-1:0]      joyS,
    input  logic                 joyD,
    output logic [PADS*BITS-1:0] joy,
    output logic                 valid,
    output logic                 changed
);

    localparam int BW = $clog2(BITS);

    // Valid/ready does not apply here: every step is paced by the one-clock ce tick,
    // and valid/changed are single-clock strobes with no back-pressure.
    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SELW-1:0]       pad_q, pad_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [PADS*BITS-1:0]  shift_q, shift_d;
    logic [PADS*BITS-1:0]  joy_q, joy_d;
    logic                  ck_q, ck_d;
    logic                  ld_q, ld_d;
    logic                  valid_q, valid_d;
    logic                  changed_q, changed_d;
    logic                  frame_end;
`ifdef JOYSCAN_DEBOUNCE_EN
    logic [PADS*BITS-1:0]  ref_q, ref_d;
`endif

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            state_q   <= ST_LOAD;
            pad_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            joy_q     <= '0;
            ck_q      <= 1'b1;
            ld_q      <= 1'b1;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
`ifdef JOYSCAN_DEBOUNCE_EN
            ref_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pad_q     <= pad_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            joy_q     <= joy_d;
            ck_q      <= ck_d;
            ld_q      <= ld_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
`ifdef JOYSCAN_DEBOUNCE_EN
            ref_q     <= ref_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pad_d     = pad_q;
        bit_d     = bit_q;
        frame_end = 1'b0;
        if (ce) begin
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_SHIFT_LO;
                    bit_d   = '0;
                end
                ST_SHIFT_LO: state_d = ST_SHIFT_HI;
                ST_SHIFT_HI: begin
                    if (bit_q == BW'(BITS - 1)) begin
                        state_d = ST_LOAD;
                        if (pad_q == SELW'(PADS - 1)) begin
                            pad_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            pad_d = pad_q + 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = ST_SHIFT_LO;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Pin drive, serial capture and frame commit; outputs are registered so
    // they change only on ce edges and come out of reset at idle levels.
    always_comb begin
        ck_d      = ck_q;
        ld_d      = ld_q;
        shift_d   = shift_q;
        joy_d     = joy_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
`ifdef JOYSCAN_DEBOUNCE_EN
        ref_d     = ref_q;
`endif
        if (ce) begin
            case (state_q)
                ST_LOAD: begin
                    ld_d = 1'b0;
                    ck_d = 1'b1;
                end
                ST_SHIFT_LO: begin
                    ld_d = 1'b1;
                    ck_d = 1'b0;
                    for (int p = 0; p < PADS; p++) begin
                        for (int b = 0; b < BITS; b++) begin
                            if (pad_q == SELW'(p) && bit_q == BW'(b)) begin
                                shift_d[p*BITS + b] = ~joyD;
                            end
                        end
                    end
                end
                ST_SHIFT_HI: ck_d = 1'b1;
                default: ;
            endcase
        end
        if (frame_end) begin
            valid_d = 1'b1;
`ifdef JOYSCAN_DEBOUNCE_EN
            if (shift_q == ref_q) begin
                joy_d     = shift_q;
                changed_d = (shift_q != joy_q);
            end
            ref_d = shift_q;
`else
            joy_d     = shift_q;
            changed_d = (shift_q != joy_q);
`endif
        end
    end

    assign joyCk   = ck_q;
    assign joyLd   = ld_q;
    assign joyS    = pad_q;
    assign joy     = joy_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule

// File: doc/joystick_scan.md
Name: joystick_scan

Overview:
- Parametrised successor to the two-pad serial joystick reader: scans PADS shift-register game pads, each BITS wide, over one shared clock/load/data bus with a binary pad-select bus.
- Sits between the board top level and the game core. Paced by an external clock enable (ce2K5-class tick).
- Publishes all pads as one flat active-high bus, with a frame-valid strobe and a change strobe.

Parameters:
- PADS, 2, number of pads scanned per frame (1..8).
- BITS, 8, bits read per pad (2..16).
- SELW, 1, width of the pad-select bus; 2**SELW >= PADS is required.

Ports:
- clock  input  1  system clock.
- power  input  1  asynchronous active-low reset; low holds the block in reset (PLL-locked signal).
- ce  input  1  scan tick; one-clock pulse; the FSM advances only on clocks with ce=1.
- joyCk  output  1  pad shift clock.
- joyLd  output  1  pad parallel-load strobe, active low.
- joyS  output  SELW  pad select; equals the index of the pad being scanned.
- joyD  input  1  serial pad data, active low (0 = pressed).
- joy  output  PADS*BITS  pad p occupies joy[p*BITS +: BITS]; 1 = pressed.
- valid  output  1  one-clock pulse when joy is updated.
- changed  output  1  one-clock pulse, coincident with valid, when the new joy differs from the previous joy.

Behaviour:
- Reset (power=0, async), or power low at any point mid-frame:
  - Frame aborts; shift registers clear.
  - Outputs: joyCk=1, joyLd=1, joyS=0, joy=0, valid=0, changed=0.
  - State=LOAD, pad=0, bit=0.
  - After power rises, the first ce starts a fresh frame at pad 0.
- FSM, advancing on clock edges with ce=1:
  - LOAD: joyLd=0, joyCk=1, joyS=pad, for one tick. Next state SHIFT_LO, bit=0.
  - SHIFT_LO: joyLd=1, joyCk=0. On leaving this state, sample ~joyD into shift bit [bit]. Next state SHIFT_HI.
  - SHIFT_HI: joyCk=1. If bit==BITS-1, go to NEXT handling; otherwise bit+1 and go to SHIFT_LO.
  - NEXT handling (same edge as the exit from SHIFT_HI):
    - If pad<PADS-1: pad+1, state LOAD.
    - Otherwise: commit all shift registers to joy; valid=1 for one clock; changed=1 if joy changes; pad=0; state LOAD.
- Bit order: the first bit sampled after the load becomes bit 0 of that pad.
- Frame length: exactly PADS*(1+2*BITS) ce ticks. Defaults give 34 ticks.
- joy is stable between valid pulses; it never shows a partially scanned frame.
- joyS changes only on the edge that enters LOAD, so it is stable for the whole pad slot.
- valid and changed are driven from clock, not ce, and are one clock wide even when ce is held high.
- ce held constantly high: one state step per clock; behaviour otherwise identical.
- PADS=1: joyS stays 0.

Optional Feature:
- JOYSCAN_DEBOUNCE_EN defined:
  - The candidate frame is committed only if it equals the previously scanned raw frame.
  - A disagreeing frame is stored as the new reference. joy is unchanged, valid still pulses at frame end, and changed=0.
  - Latency from a stable input change to joy is two frames.
  - The reference register clears on reset.
- Undefined: every frame commits directly, with no extra registers.

Test Plan:
- Reset then ce every 4 clocks, defaults, joyD constantly 1 -> joyLd low once every 17 ticks; joyS=0 for ticks 0..16 and 1 for ticks 17..33; valid every 34 ticks; joy=16'h0000; changed never asserts.
- Pad 0 drives serial 0,1,1,1,1,1,1,0 (first bit first), pad 1 all 1 -> after first frame joy=16'h0081, valid=1, changed=1; next identical frame gives changed=0.
- PADS=4, BITS=12, SELW=2 -> joyS steps 0,1,2,3 in 25-tick slots; frame is 100 ticks; joy is 48 bits with pad 3 in [47:36].
- power pulled low during the pad 1 shift, at the fifth bit -> outputs return to reset values immediately and asynchronously; the next frame starts at pad 0 with LOAD; no valid pulses for the aborted frame.
- ce tied high -> valid one clock wide every 34 clocks; joyCk toggles every clock during shift.
- JOYSCAN_DEBOUNCE_EN, a single-frame glitch on pad 0 bit 3 -> joy unchanged, changed=0. Holding the press for two frames sets joy[3]=1 on the second valid.
